seq_detect_scheduler: RTL
=========================

Name: seq_detect_scheduler

Overview:
- Time-shares one internal consecutive-run detector among NUM_CH serial bit streams.
- The detector is a run-length matcher that flags RUN_LEN consecutive identical bits.
- Requesters ask for a detection window. A round-robin scheduler grants one channel at a time, resets the detector's state, runs it for up to WINDOW samples, and reports the result.
- Sits between the serial front-ends and the status/interrupt logic of the FSM test subsystem.

Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- RUN_LEN, 3: consecutive identical bits that constitute a hit (2..15).
- WINDOW, 8: maximum samples per granted window (RUN_LEN..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_CH  per-channel window request, level; held until done for that channel.
- x_in  in  NUM_CH  per-channel serial data bit.
- grant  out  NUM_CH  one-hot grant, registered; all-zero when idle.
- busy  out  1  high in ARB, RUN and REPORT.
- done  out  1  one-cycle pulse at window end.
- done_ch  out  $clog2(NUM_CH)  channel index of the finished window; valid when done=1.
- hit  out  1  run found in the window; valid when done=1.
- aborted  out  1  window ended by request withdrawal; valid when done=1.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, grant=0, busy=0, done=0, done_ch=0, hit=0, aborted=0.
  - rr_ptr=0; detector count=0, last bit=0.
- States:
  - IDLE: if req!=0, go to ARB; else stay.
  - ARB (1 cycle):
    - Pick the first set req bit searching from rr_ptr upward with wrap.
    - Latch its index into ch; set grant to onehot(ch); clear detector (cnt=0, sample_cnt=0, hit_r=0).
    - Go to RUN.
    - If req went to 0 during ARB, return to IDLE with no grant and no done.
  - RUN: one sample of x_in[ch] per cycle; sample_cnt increments.
    - Detector update, first sample: cnt=1, last=x.
    - Later samples: if x==last then cnt=min(cnt+1, RUN_LEN), else cnt=1; last=x.
    - hit_r set when the updated cnt==RUN_LEN. The sample that completes the run counts.
    - Exit to REPORT when any of the following holds:
      - hit_r becomes set (early termination);
      - sample_cnt reaches WINDOW;
      - req[ch]==0 (abort, evaluated before sampling that cycle).
  - REPORT (1 cycle):
    - done=1, done_ch=ch, hit=hit_r, aborted=abort flag; grant=0.
    - rr_ptr=(ch+1) mod NUM_CH.
    - Go to IDLE.
- Latency:
  - req rising in IDLE → grant visible 2 edges later.
  - done occurs 1 cycle after the final RUN sample.
  - A window needing k samples has grant high for exactly k cycles.
- Boundary cases:
  - Hit and WINDOW reached on the same sample: hit=1, aborted=0.
  - Abort takes priority over WINDOW; a hit latched earlier is never lost.
  - hit and aborted are never both 1. An abort on a cycle whose sample would hit reports aborted=1, hit=0, because the abort check precedes sampling.
  - A single requester is re-granted back-to-back with one IDLE cycle between windows.
  - rr_ptr wraps from NUM_CH-1 to 0.
  - x_in of non-granted channels is ignored.
  - Reset mid-RUN: outputs return to reset values immediately; no done is issued.

Optional Feature:
- Macro: SEQ_SCHED_HIT_COUNT_EN.
- Defined:
  - Adds inputs cnt_sel (width $clog2(NUM_CH)) and cnt_clr (1).
  - Adds output hit_count (8 bits) = the saturating count (max 255) of done pulses with hit=1 for channel cnt_sel. Combinational read of registered counters.
  - cnt_clr zeroes all counters on the next edge. If cnt_clr coincides with a hit report, the clear wins.
  - Counters reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
All scenarios use NUM_CH=4, RUN_LEN=3, WINDOW=8.
1. req=0001, x_in[0]=1,0,1,1,1 → grant=0001 for 5 cycles; done with done_ch=0, hit=1, aborted=0.
2. req=0010, x_in[1] alternating 1,0,… → grant high for 8 cycles; done with hit=0, aborted=0, done_ch=1.
3. req=1111 held, each stream 0,0,0 → dones in order ch 0,1,2,3,0, each with hit=1; one IDLE cycle between windows.
4. req=0100; drop req[2] after 2 samples → done with aborted=1, hit=0; grant cleared; the next window starts from rr_ptr=3.
5. Assert reset_n=0 during RUN on ch1 → grant, busy and done go to 0 asynchronously. After release with req=0010, the window starts fresh (cnt cleared).
6. SEQ_SCHED_HIT_COUNT_EN defined: 3 hits on ch2 → hit_count=3 with cnt_sel=2. Pulse cnt_clr → hit_count=0.

Source files
------------

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler that time-shares one consecutive-run detector among NUM_CH serial streams.
// Optional per-channel hit tally (hit_count, cnt_sel, cnt_clr) is built when SEQ_SCHED_HIT_COUNT_EN is defined.
module seq_detect_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int RUN_LEN = 3,
  parameter int WINDOW  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH-1:0]         x_in,
`ifdef SEQ_SCHED_HIT_COUNT_EN
  input  logic [$clog2(NUM_CH)-1:0] cnt_sel,
  input  logic                      cnt_clr,
  output logic [7:0]                hit_count,
`endif
  output logic [NUM_CH-1:0]         grant,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NUM_CH)-1:0] done_ch,
  output logic                      hit,
  output logic                      aborted
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   pick;
  logic [CH_W-1:0]   idx;
  logic              pick_vld;

  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic [7:0]        sample_cnt;
  logic              hit_r;

  logic              x_cur;
  logic [CNT_W-1:0]  cnt_upd;
  logic              hit_upd;
  logic [7:0]        sample_upd;
  logic              abort_now;
  logic              run_end;

  // Round-robin pick: lowest offset from rr_ptr wins, so scan offsets high to low.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Detector update for the current RUN sample; cnt==0 marks the first sample of a window.
  always_comb begin
    x_cur      = x_in[ch];
    abort_now  = ~req[ch];
    sample_upd = sample_cnt + 8'd1;
    if (cnt == '0) begin
      cnt_upd = CNT_W'(1);
    end else if (x_cur == last) begin
      cnt_upd = (cnt == CNT_W'(RUN_LEN)) ? cnt : cnt + CNT_W'(1);
    end else begin
      cnt_upd = CNT_W'(1);
    end
    hit_upd = hit_r | (cnt_upd == CNT_W'(RUN_LEN));
    run_end = abort_now | hit_upd | (sample_upd == 8'(WINDOW));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ARB;
      ARB:     state_nxt = pick_vld ? RUN : IDLE;
      RUN:     if (run_end) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Window datapath: grant, detector state and the registered report fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch         <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      last       <= 1'b0;
      sample_cnt <= '0;
      hit_r      <= 1'b0;
      grant      <= '0;
      done       <= 1'b0;
      done_ch    <= '0;
      hit        <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ARB: begin
          if (pick_vld) begin
            ch         <= pick;
            grant      <= NUM_CH'(1) << pick;
            cnt        <= '0;
            sample_cnt <= '0;
            hit_r      <= 1'b0;
          end
        end
        RUN: begin
          if (abort_now) begin
            // Withdrawal is checked before sampling, so this cycle's bit never counts.
            grant   <= '0;
            done    <= 1'b1;
            done_ch <= ch;
            hit     <= hit_r;
            aborted <= 1'b1;
          end else begin
            cnt        <= cnt_upd;
            last       <= x_cur;
            sample_cnt <= sample_upd;
            hit_r      <= hit_upd;
            if (run_end) begin
              grant   <= '0;
              done    <= 1'b1;
              done_ch <= ch;
              hit     <= hit_upd;
              aborted <= 1'b0;
            end
          end
        end
        REPORT: begin
          rr_ptr <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_SCHED_HIT_COUNT_EN
  logic [7:0] hit_tally [NUM_CH];

  // Counts hit reports per channel, saturating at 255; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) hit_tally[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_CH; i++) hit_tally[i] <= '0;
    end else if (done && hit && (hit_tally[done_ch] != 8'hFF)) begin
      hit_tally[done_ch] <= hit_tally[done_ch] + 8'd1;
    end
  end

  assign hit_count = hit_tally[cnt_sel];
`endif

endmodule
